// File: rtl/dsp_cfg_pkg.sv
// Shared definitions for the DSP column frame sequencer: FSM states and CRC-16-CCITT helpers.
package dsp_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

    localparam logic [15:0] DSP_CRC_POLY = 16'h1021;
    localparam logic [15:0] DSP_CRC_INIT = 16'hFFFF;
    localparam int unsigned DSP_ROW_W    = 32;

    // Shift one data bit (MSB-first order) into a CRC-16-CCITT register.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? DSP_CRC_POLY : 16'h0000);
    endfunction

    // Fold a full 32-bit frame row, MSB first, into a running CRC.
    function automatic logic [15:0] crc16_row(input logic [15:0] crc_in,
                                              input logic [DSP_ROW_W-1:0] row);
        logic [15:0] c;
        c = crc_in;
        for (int i = DSP_ROW_W - 1; i >= 0; i--) begin
            c = crc16_bit(c, row[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsp_frame_crc.sv
// CRC-16-CCITT accumulator over accepted frame rows; one full row folded per cycle.
module dsp_frame_crc
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [15:0]  crc
);

    logic [15:0] fold;

    // Fold the row into the current CRC, restarting from init when cleared in the same cycle.
    always_comb begin
        fold = clr ? DSP_CRC_INIT : crc;
        for (int i = W - 1; i >= 0; i--) begin
            fold = crc16_bit(fold, data[i]);
        end
    end

    // CRC register: accumulate on acceptance, restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= DSP_CRC_INIT;
        end else if (en) begin
            crc <= fold;
        end else if (clr) begin
            crc <= DSP_CRC_INIT;
        end
    end

endmodule

// File: rtl/dsp_col_frame_sequencer.sv
// Frame write sequencer for one DSP tile column: FrameData setup, one-hot FrameStrobe pulse, hold,
// and a sticky written mask. Optional CRC over accepted rows is enabled by DSP_FRAME_CRC_EN.
module dsp_col_frame_sequencer
    import dsp_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned STROBE_CYCLES   = 2,
    localparam int unsigned AW             = $clog2(MaxFramesPerCol)
) (
    input  logic                       UserCLK,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [AW-1:0]              s_addr,
    input  logic [FrameBitsPerRow-1:0] s_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       clr,
    output logic [MaxFramesPerCol-1:0] written,
    output logic                       all_written
`ifdef DSP_FRAME_CRC_EN
    ,
    output logic [15:0]                crc
`endif
);

    if ((STROBE_CYCLES < 1) || (STROBE_CYCLES > 15)) begin : g_bad_strobe
        $error("STROBE_CYCLES must be in 1..15");
    end

    seq_state_e                 state, state_nxt;
    logic [3:0]                 cnt_q, cnt_nxt;
    logic [AW-1:0]              addr_q;
    logic                       addr_ok, accept, reject;
    logic [MaxFramesPerCol-1:0] onehot, hold_mask;
    logic [FrameBitsPerRow-1:0] data_nxt;
    logic [MaxFramesPerCol-1:0] strobe_nxt, written_nxt;
    logic                       done_nxt, err_nxt;

    assign addr_ok = 32'(s_addr) < MaxFramesPerCol;
    assign accept  = (state == ST_IDLE) && s_valid && addr_ok;
    assign reject  = (state == ST_IDLE) && s_valid && !addr_ok;
    assign onehot  = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << addr_q;

    assign s_ready     = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign all_written = &written;

    // State, counter, latched address and registered outputs.
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            written     <= '0;
        end else begin
            state       <= state_nxt;
            cnt_q       <= cnt_nxt;
            if (accept) begin
                addr_q <= s_addr;
            end
            FrameData   <= data_nxt;
            FrameStrobe <= strobe_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            written     <= written_nxt;
        end
    end

    // Next-state and strobe-length counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                cnt_nxt   = 4'(STROBE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = ST_HOLD;
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; a clear coinciding with the HOLD set keeps that bit.
    always_comb begin
        data_nxt    = FrameData;
        strobe_nxt  = '0;
        done_nxt    = 1'b0;
        err_nxt     = reject;
        hold_mask   = '0;
        if (accept) begin
            data_nxt = s_data;
        end
        if (state_nxt == ST_STROBE) begin
            strobe_nxt = onehot;
        end
        if ((state == ST_STROBE) && (state_nxt == ST_HOLD)) begin
            done_nxt = 1'b1;
        end
        if ((state_nxt == ST_HOLD) || (state == ST_HOLD)) begin
            hold_mask = onehot;
        end
        written_nxt = (clr ? '0 : written) | hold_mask;
    end

`ifdef DSP_FRAME_CRC_EN
    dsp_frame_crc #(
        .W (FrameBitsPerRow)
    ) u_crc (
        .clk  (UserCLK),
        .rst  (reset),
        .clr  (clr),
        .en   (accept),
        .data (s_data),
        .crc  (crc)
    );
`endif

endmodule

// File: tb/tb_dsp_col_frame_sequencer.sv
// Directed self-checking bench for dsp_col_frame_sequencer (CRC checks compile under DSP_FRAME_CRC_EN).
module tb_dsp_col_frame_sequencer;
    import dsp_cfg_pkg::*;

    logic        UserCLK;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        busy;
    logic        done;
    logic        err;
    logic        clr;
    logic [19:0] written;
    logic        all_written;
`ifdef DSP_FRAME_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_exp;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] wr_exp;
    int low_cnt;

    dsp_col_frame_sequencer dut (
        .UserCLK     (UserCLK),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .clr         (clr),
        .written     (written),
        .all_written (all_written)
`ifdef DSP_FRAME_CRC_EN
        ,
        .crc         (crc)
`endif
    );

    always #5 UserCLK = ~UserCLK;

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Complete one frame write and return in IDLE.
    task automatic do_frame(input logic [4:0] a, input logic [31:0] d);
        s_valid = 1'b1;
        s_addr  = a;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        UserCLK = 1'b0;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_addr  = '0;
        s_data  = '0;
        clr     = 1'b0;
        repeat (2) @(posedge UserCLK);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_data", FrameData, 32'h0);
        chk("rst_strobe", 32'(FrameStrobe), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_written", 32'(written), 32'h0);
        chk("rst_allw", 32'(all_written), 32'd0);
`ifdef DSP_FRAME_CRC_EN
        chk("rst_crc", 32'(crc), 32'hFFFF);
`endif

        // Single frame 3
        s_valid = 1'b1;
        s_addr  = 5'd3;
        s_data  = 32'hA5A5_0001;
        tick();
        s_valid = 1'b0;
        s_data  = 32'h0;
        chk("f3_setup_ready", 32'(s_ready), 32'd0);
        chk("f3_setup_busy", 32'(busy), 32'd1);
        chk("f3_setup_strobe", 32'(FrameStrobe), 32'h0);
        chk("f3_setup_data", FrameData, 32'hA5A5_0001);
        tick();
        chk("f3_strobe1", 32'(FrameStrobe), 32'h00008);
        chk("f3_strobe1_data", FrameData, 32'hA5A5_0001);
        tick();
        chk("f3_strobe2", 32'(FrameStrobe), 32'h00008);
        chk("f3_strobe2_done", 32'(done), 32'd0);
        tick();
        chk("f3_hold_strobe", 32'(FrameStrobe), 32'h0);
        chk("f3_hold_done", 32'(done), 32'd1);
        chk("f3_hold_written", 32'(written), 32'h00008);
        chk("f3_hold_data", FrameData, 32'hA5A5_0001);
        chk("f3_hold_ready", 32'(s_ready), 32'd0);
        tick();
        chk("f3_idle_ready", 32'(s_ready), 32'd1);
        chk("f3_idle_done", 32'(done), 32'd0);
        chk("f3_idle_data", FrameData, 32'hA5A5_0001);

        // Back-to-back frames 0..19 with s_valid held high
        wr_exp  = 20'h00008;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_addr = 5'(i);
            s_data = 32'h1000_0000 + 32'(i);
            tick();
            low_cnt = (s_ready == 1'b0) ? 1 : 0;
            repeat (3) begin
                tick();
                if (s_ready == 1'b0) low_cnt++;
            end
            wr_exp = wr_exp | (20'h1 << i);
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_written", 32'(written), 32'(wr_exp));
            chk("b2b_allw", 32'(all_written), (i == 19) ? 32'd1 : 32'd0);
            tick();
            chk("b2b_ready_low_cycles", 32'(low_cnt), 32'd4);
            chk("b2b_ready_back", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;

        // Bad index 25
        s_valid = 1'b1;
        s_addr  = 5'd25;
        s_data  = 32'hDEAD_BEEF;
        tick();
        s_valid = 1'b0;
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_ready", 32'(s_ready), 32'd1);
        chk("bad_strobe", 32'(FrameStrobe), 32'h0);
        chk("bad_written", 32'(written), 32'hFFFFF);
        chk("bad_data", FrameData, 32'h1000_0013);
        tick();
        chk("bad_err_clear", 32'(err), 32'd0);
        chk("bad_strobe2", 32'(FrameStrobe), 32'h0);

        // clr coinciding with HOLD of frame 5
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_written", 32'(written), 32'h0);
        chk("clr_allw", 32'(all_written), 32'd0);
        do_frame(5'd0, 32'h0000_0100);
        do_frame(5'd1, 32'h0000_0101);
        chk("pre5_written", 32'(written), 32'h00003);
        s_valid = 1'b1;
        s_addr  = 5'd5;
        s_data  = 32'h0000_0505;
        tick();
        s_valid = 1'b0;
        repeat (3) tick();
        chk("f5_hold_done", 32'(done), 32'd1);
        chk("f5_hold_written", 32'(written), 32'h00023);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("f5_clr_written", 32'(written), 32'h00020);

        // Reset during second strobe cycle of frame 7
        s_valid = 1'b1;
        s_addr  = 5'd7;
        s_data  = 32'h0000_0707;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("f7_strobe2", 32'(FrameStrobe), 32'h00080);
        #2 reset = 1'b1;
        #1;
        chk("f7_async_strobe", 32'(FrameStrobe), 32'h0);
        chk("f7_async_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("f7_post_ready", 32'(s_ready), 32'd1);
        chk("f7_post_busy", 32'(busy), 32'd0);
        chk("f7_post_written", 32'(written), 32'h0);
        chk("f7_post_done", 32'(done), 32'd0);
        chk("f7_post_strobe", 32'(FrameStrobe), 32'h0);

`ifdef DSP_FRAME_CRC_EN
        // CRC over two rows, then clear
        chk("crc_after_reset", 32'(crc), 32'hFFFF);
        do_frame(5'd2, 32'h0000_0000);
        crc_exp = crc16_row(DSP_CRC_INIT, 32'h0000_0000);
        chk("crc_row0", 32'(crc), 32'(crc_exp));
        do_frame(5'd4, 32'hFFFF_FFFF);
        crc_exp = crc16_row(crc_exp, 32'hFFFF_FFFF);
        chk("crc_row1", 32'(crc), 32'(crc_exp));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("crc_clr", 32'(crc), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_col_frame_sequencer.md
# dsp_col_frame_sequencer

Configuration frame sequencer for one DSP tile column of the eFPGA fabric. It accepts frame-write requests (frame index plus one row of frame data) over a valid/ready handshake. For each accepted write it drives the column's `FrameData` row and produces a one-hot, multi-cycle `FrameStrobe` pulse with setup and hold around it. It sits between the fabric configuration port and the column's `FrameStrobe` input chain, which feeds the DSP body tiles and the N_term tile at the top. It also tracks which frames of the column have been written.

## Interface
Parameters:
- `MaxFramesPerCol`, 20: number of strobe lines per column.
- `FrameBitsPerRow`, 32: width of one frame data row.
- `STROBE_CYCLES`, 2: strobe high time in cycles; legal range 1..15.
- `AW`, `$clog2(MaxFramesPerCol)`: frame index width; derived, not overridden.

Ports (one clock; reset is asynchronous and active-high):
- `UserCLK`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: frame write request.
- `s_ready`  out  1: sequencer can accept a request.
- `s_addr`  in  AW: target frame index.
- `s_data`  in  FrameBitsPerRow: frame data row.
- `FrameData`  out  FrameBitsPerRow: row driven to the column.
- `FrameStrobe`  out  MaxFramesPerCol: one-hot strobe to the column.
- `busy`  out  1: a sequence is in progress.
- `done`  out  1: one-cycle pulse when a frame completes.
- `err`  out  1: one-cycle pulse when a request is rejected for a bad index.
- `clr`  in  1: synchronous clear of `written` (and of the CRC, when compiled in).
- `written`  out  MaxFramesPerCol: sticky mask of frames written.
- `all_written`  out  1: `&written`.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - `s_ready`=1.
  - On `s_valid` with `s_addr < MaxFramesPerCol`: latch address and data into internal registers, go to SETUP.
  - On `s_valid` with `s_addr >= MaxFramesPerCol`: consume the request (handshake completes), pulse `err` next cycle, stay in IDLE, leave outputs unchanged.
- SETUP (1 cycle): `FrameData` = latched data; `FrameStrobe`=0; go to STROBE.
- STROBE (`STROBE_CYCLES` cycles, via a 4-bit down-counter): `FrameStrobe` = one-hot of the latched address; `FrameData` held. When the counter expires, go to HOLD.
- HOLD (1 cycle):
  - `FrameStrobe`=0; `FrameData` held.
  - Pulse `done` and set the `written` bit for the address.
  - Go to IDLE.
- `s_ready`=0 in every state except IDLE; no request queuing.
- `FrameData` keeps its last value in IDLE and changes only on entry to SETUP.
- `busy` = (state != IDLE).
- `clr`:
  - Clears `written` in the cycle it is sampled.
  - If `clr` and the HOLD set occur in the same cycle, the set wins for that bit; all other bits clear.
- `FrameStrobe` is never multi-hot and is never nonzero outside STROBE.
- Reset values: state IDLE, `s_ready` 1, `FrameData` 0, `FrameStrobe` 0, `busy` 0, `done` 0, `err` 0, `written` 0, `all_written` 0.
- Reset asserted mid-sequence drops `FrameStrobe` to 0 immediately (asynchronously). The in-flight frame is not marked written.

## Timing
- Request accepted on edge T0:
  - SETUP during T0..T1.
  - Strobe high for edges T1 through T1+STROBE_CYCLES.
  - `done` high in the HOLD cycle, T1+STROBE_CYCLES..T2+STROBE_CYCLES.
  - `s_ready` high again after edge T2+STROBE_CYCLES.
- Period per frame: `STROBE_CYCLES`+3 cycles, including the accept cycle.
- Rejected request: `err` high in the cycle after acceptance; `s_ready` stays high, so back-to-back requests are possible.
- All outputs are registered except `s_ready`, `busy` and `all_written`, which decode registered state.

## Configuration
- Macro: `DSP_FRAME_CRC_EN`.
- When defined:
  - Adds output `crc` (16 bits): CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, MSB first) accumulated over `s_data` of every accepted valid-address request.
  - The full row is folded in one cycle at acceptance.
  - `crc` resets to 0xFFFF and is set to 0xFFFF by `clr`.
- When undefined: no `crc` port and no CRC logic; behaviour is otherwise identical.

## Structure
- Shared package `dsp_cfg_pkg`:
  - FSM state enum.
  - `DSP_CRC_POLY` (16'h1021) and `DSP_CRC_INIT` (16'hFFFF).
  - Function `crc16_row` (data row in, CRC out), shared with the bench model.
- One sub-module, `dsp_frame_crc`: the CRC accumulator. It is instantiated only under `DSP_FRAME_CRC_EN`.

## Test plan
- Reset, then `s_addr`=3, `s_data`=32'hA5A5_0001, default `STROBE_CYCLES`:
  - `FrameStrobe`=20'h00008 for exactly 2 cycles.
  - `FrameData` stable from SETUP through HOLD.
  - `done` pulses once; `written`=20'h00008; 5-cycle period.
- Write frames 0..19 back-to-back with `s_valid` held high:
  - `all_written` rises with the final `done`.
  - `s_ready` low for exactly 4 cycles between accepts.
- `s_addr`=25:
  - `err` pulses for 1 cycle; no strobe; `written` unchanged.
  - `s_ready` stays 1.
- Assert `reset` during the second STROBE cycle of frame 7:
  - `FrameStrobe`=0 immediately.
  - After release: `written`=0, state IDLE.
- `clr` in the same cycle as the HOLD of frame 5, with `written` previously 20'h00003: `written`=20'h00020.
- With `DSP_FRAME_CRC_EN` defined, write data rows 32'h0000_0000 then 32'hFFFF_FFFF: `crc` matches `crc16_row` applied in sequence from 0xFFFF; `clr` returns it to 0xFFFF.
